// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the buffered UART transmitter
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic [3:0] ADDR_TXDATA = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h1;
  localparam logic [3:0] ADDR_CTRL   = 4'h2;
  localparam logic [3:0] ADDR_LEVEL  = 4'h3;

  // Field order puts par_en at bit 0 so the struct maps directly onto the CTRL register.
  typedef struct packed {
    logic irq_en;
    logic stop2;
    logic par_odd;
    logic par_en;
  } ctrl_t;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;

  // Rounded clock cycles per bit period.
  function automatic int calc_div(input int clk_freq, input int baud_rate);
    return (clk_freq + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous transmit FIFO with occupancy count
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     arst_n_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // The extra pointer MSB separates "wrapped once" (full) from "equal" (empty).
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

  // Read and write pointer advance.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_core.sv
// rtl/uart_tx_fifo_core.sv - Avalon-MM UART transmitter with TX FIFO, parity and stop-bit control
module uart_tx_fifo_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       arst_n_i,
  input  logic [3:0] avms_address_i,
  input  logic       avms_read_i,
  input  logic       avms_write_i,
  input  logic [7:0] avms_writedata_i,
  output logic [7:0] avms_readdata_o,
  output logic       irq_o,
  output logic       uart_txd_o
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W = $clog2(2 * DIV);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] STOP2_LAST = CNT_W'(2 * DIV - 1);
  localparam logic [2:0]       BIT_LAST   = 3'(DATA_BITS - 1);

  // Register file
  ctrl_t      ctrl_q;
  logic       ovf_q;
  logic [7:0] rdata_q;
  logic [7:0] rd_mux;

  // Bus decode
  logic wr_txdata;
  logic wr_status;
  logic wr_ctrl;
  logic push_drop;

  // FIFO
  logic                 fifo_pop;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [LVL_W-1:0]     fifo_level;

  // Transmit engine
  tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  ctrl_t                frame_ctrl_q, frame_ctrl_d;
  logic                 txd_q, txd_d;
  logic                 baud_done;
  logic [CNT_W-1:0]     stop_last;
  logic                 busy;

  assign wr_txdata = avms_write_i & (avms_address_i == ADDR_TXDATA);
  assign wr_status = avms_write_i & (avms_address_i == ADDR_STATUS);
  assign wr_ctrl   = avms_write_i & (avms_address_i == ADDR_CTRL);

  // Full FIFO drops the byte unless the engine pops in the same cycle.
  assign push_drop = wr_txdata & fifo_full & ~fifo_pop;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .push_i   (wr_txdata),
    .wdata_i  (avms_writedata_i[DATA_BITS-1:0]),
    .pop_i    (fifo_pop),
    .rdata_o  (fifo_rdata),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .level_o  (fifo_level)
  );

  assign busy      = (state_q != ST_IDLE);
  assign baud_done = (cnt_q == DIV_LAST);
  assign stop_last = frame_ctrl_q.stop2 ? STOP2_LAST : DIV_LAST;

  // Read mux for the registered read data port.
  always_comb begin
    rd_mux = 8'h00;
    case (avms_address_i)
      ADDR_STATUS: begin
        rd_mux[STAT_BUSY]  = busy;
        rd_mux[STAT_FULL]  = fifo_full;
        rd_mux[STAT_EMPTY] = fifo_empty;
        rd_mux[STAT_OVF]   = ovf_q;
      end
      ADDR_CTRL:  rd_mux = {4'b0000, ctrl_q};
      ADDR_LEVEL: rd_mux = 8'(fifo_level);
      default:    rd_mux = 8'h00;
    endcase
  end

  // CTRL, sticky overflow and read data registers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      ctrl_q  <= '0;
      ovf_q   <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      if (wr_ctrl) begin
        ctrl_q <= ctrl_t'(avms_writedata_i[3:0]);
      end
      if (push_drop) begin
        ovf_q <= 1'b1;
      end else if (wr_status && avms_writedata_i[STAT_OVF]) begin
        ovf_q <= 1'b0;
      end
      if (avms_read_i) begin
        rdata_q <= rd_mux;
      end
    end
  end

  // Frame sequencer: baud counter, bit counter, shift register and line value.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    par_d        = par_q;
    frame_ctrl_d = frame_ctrl_q;
    fifo_pop     = 1'b0;
    txd_d        = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) fifo_pop = 1'b1;
      end
      ST_START: begin
        if (baud_done) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = frame_ctrl_q.par_en ? ST_PARITY : ST_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PARITY: begin
        if (baud_done) begin
          cnt_d   = '0;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == stop_last) begin
          cnt_d = '0;
          if (!fifo_empty) fifo_pop = 1'b1;
          else             state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A pop starts the next frame with a snapshot of CTRL, so later CTRL writes wait for it.
    if (fifo_pop) begin
      state_d      = ST_START;
      cnt_d        = '0;
      shift_d      = fifo_rdata;
      par_d        = (^fifo_rdata) ^ ctrl_q.par_odd;
      frame_ctrl_d = ctrl_q;
    end

    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
      ST_PARITY: txd_d = par_d;
      default:   txd_d = 1'b1;
    endcase
  end

  // Transmit engine state; the line register resets high so a reset mid-frame idles the line.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_q        <= 3'd0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      frame_ctrl_q <= '0;
      txd_q        <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      frame_ctrl_q <= frame_ctrl_d;
      txd_q        <= txd_d;
    end
  end

  assign avms_readdata_o = rdata_q;
  assign uart_txd_o      = txd_q;
  assign irq_o           = ctrl_q.irq_en & fifo_empty & (state_q == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo_core.sv
// tb/tb_uart_tx_fifo_core.sv - self-checking bench for uart_tx_fifo_core
module tb_uart_tx_fifo_core;

  localparam int DIV  = 10;
  localparam int LOGN = 16384;

  logic       clk = 1'b0;
  logic       arst_n;
  logic [3:0] addr;
  logic       rd;
  logic       wr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       irq;
  logic       txd;

  uart_tx_fifo_core #(
    .CLK_FREQ   (1_000_000),
    .BAUD_RATE  (100_000),
    .DATA_BITS  (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i            (clk),
    .arst_n_i         (arst_n),
    .avms_address_i   (addr),
    .avms_read_i      (rd),
    .avms_write_i     (wr),
    .avms_writedata_i (wdata),
    .avms_readdata_o  (rdata),
    .irq_o            (irq),
    .uart_txd_o       (txd)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic txlog  [LOGN];
  logic irqlog [LOGN];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < LOGN) begin
      txlog[cyc]  <= txd;
      irqlog[cyc] <= irq;
    end
  end

  int   vectors = 0;
  int   miscompares = 0;
  int   last_wr;
  logic ew[$];

  typedef struct {
    logic       is_wr;
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] exp_rd;
    logic       exp_irq;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    addr = a; wdata = d; wr = 1'b1; last_wr = cyc;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
    addr = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    d = rdata;
  endtask

  // Expected line: start, LSB-first data, optional parity, one or two stop periods.
  task automatic add_frame(input logic [7:0] b, input logic [3:0] c);
    repeat (DIV) ew.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (DIV) ew.push_back(b[i]);
    if (c[0]) repeat (DIV) ew.push_back((^b) ^ c[1]);
    repeat (c[2] ? 2 * DIV : DIV) ew.push_back(1'b1);
  endtask

  task automatic check_wave(input string name, input int start);
    int bad;
    bad = 0;
    wait_until(start + ew.size() + 2);
    if (txlog[start-1] !== 1'b1) bad++;
    for (int j = 0; j < ew.size(); j++) begin
      if (txlog[start+j] !== ew[j]) bad++;
    end
    if (txlog[start+ew.size()] !== 1'b1) bad++;
    chk(name, bad, 0);
    ew.delete();
  endtask

  function automatic int find_fall(input int from, input int to);
    for (int c = from; c <= to; c++) begin
      if (txlog[c] === 1'b0 && txlog[c-1] === 1'b1) return c;
    end
    return -1;
  endfunction

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] rb[6];
    logic [3:0] c;
    int n, s, r, k, sent, lvl, ones;
    logic ovf;

    vt[0]  = '{1'b0, 4'h1, 8'h00, 8'h04, 1'b0};
    vt[1]  = '{1'b0, 4'h2, 8'h00, 8'h00, 1'b0};
    vt[2]  = '{1'b0, 4'h3, 8'h00, 8'h00, 1'b0};
    vt[3]  = '{1'b0, 4'h0, 8'h00, 8'h00, 1'b0};
    vt[4]  = '{1'b0, 4'hF, 8'h00, 8'h00, 1'b0};
    vt[5]  = '{1'b1, 4'h2, 8'h0F, 8'h00, 1'b1};
    vt[6]  = '{1'b0, 4'h2, 8'h00, 8'h0F, 1'b1};
    vt[7]  = '{1'b1, 4'h2, 8'hF6, 8'h00, 1'b0};
    vt[8]  = '{1'b0, 4'h2, 8'h00, 8'h06, 1'b0};
    vt[9]  = '{1'b1, 4'h5, 8'hFF, 8'h00, 1'b0};
    vt[10] = '{1'b0, 4'h5, 8'h00, 8'h00, 1'b0};
    vt[11] = '{1'b0, 4'h2, 8'h00, 8'h06, 1'b0};
    vt[12] = '{1'b1, 4'h1, 8'h08, 8'h00, 1'b0};
    vt[13] = '{1'b0, 4'h1, 8'h00, 8'h04, 1'b0};
    vt[14] = '{1'b1, 4'h2, 8'h00, 8'h00, 1'b0};
    vt[15] = '{1'b0, 4'h2, 8'h00, 8'h00, 1'b0};

    arst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = 4'h0; wdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset uart_txd_o", txd, 1);
    chk("reset readdata", rdata, 8'h00);
    chk("reset irq_o", irq, 0);
    arst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      if (vt[i].is_wr) begin
        bus_write(vt[i].a, vt[i].d);
      end else begin
        bus_read(vt[i].a, d);
        chk($sformatf("table[%0d] readdata", i), d, vt[i].exp_rd);
      end
      chk($sformatf("table[%0d] irq_o", i), irq, vt[i].exp_irq);
    end

    // Basic frame: line low two cycles after the write, 100-cycle frame, no irq.
    bus_write(4'h0, 8'h55);
    n = last_wr;
    add_frame(8'h55, 4'h0);
    check_wave("basic 0x55 frame", n + 2);
    chk("basic start cycle", find_fall(n, n + 20), n + 2);
    ones = 0;
    for (int j = n; j <= n + 105; j++) if (irqlog[j] !== 1'b0) ones++;
    chk("irq low with IRQ_EN=0", ones, 0);

    bus_write(4'h0, 8'hA3);
    n = last_wr;
    wait_until(n + 30);
    bus_read(4'h1, d);
    chk("status busy mid-frame", d, 8'h05);
    add_frame(8'hA3, 4'h0);
    check_wave("frame 0xA3", n + 2);
    bus_read(4'h1, d);
    chk("status idle after frame", d, 8'h04);

    // Parity and stop bits; CTRL written mid-frame must not affect the frame in flight.
    bus_write(4'h2, 8'h05);
    bus_write(4'h0, 8'h07);
    n = last_wr;
    add_frame(8'h07, 4'h5);
    check_wave("even parity STOP2 frame", n + 2);
    bus_write(4'h2, 8'h03);
    bus_write(4'h0, 8'h07);
    n = last_wr;
    wait_until(n + 20);
    bus_write(4'h2, 8'h00);
    add_frame(8'h07, 4'h3);
    check_wave("odd parity frame with mid-frame CTRL write", n + 2);
    bus_write(4'h0, 8'hC8);
    n = last_wr;
    add_frame(8'hC8, 4'h0);
    check_wave("frame after CTRL change", n + 2);

    // Burst of six into a four-deep FIFO: sixth byte dropped, overflow sticky.
    for (int i = 1; i <= 6; i++) begin
      bus_write(4'h0, 8'(i));
      if (i == 1) n = last_wr;
    end
    bus_read(4'h3, d);
    chk("burst LEVEL", d, 8'h04);
    bus_read(4'h1, d);
    chk("burst STATUS full+overflow", d, 8'h0B);
    bus_write(4'h1, 8'h08);
    bus_read(4'h1, d);
    chk("STATUS after overflow clear", d, 8'h03);
    for (int i = 1; i <= 5; i++) add_frame(8'(i), 4'h0);
    s = n + 2 + 500;
    check_wave("burst 0x01..0x05 back-to-back", n + 2);
    wait_until(s + 125);
    chk("no frame for dropped byte", find_fall(s, s + 120), -1);
    bus_read(4'h3, d);
    chk("LEVEL after burst drained", d, 8'h00);

    // Write timed onto the pop cycle of a full FIFO is accepted.
    for (int i = 0; i < 5; i++) begin
      bus_write(4'h0, 8'hA0 + 8'(i));
      if (i == 0) n = last_wr;
    end
    bus_read(4'h1, d);
    chk("STATUS full before pop", d, 8'h03);
    wait_until(n + 101);
    bus_write(4'h0, 8'hA5);
    bus_read(4'h3, d);
    chk("LEVEL after push on pop cycle", d, 8'h04);
    bus_read(4'h1, d);
    chk("no overflow on push at pop", d, 8'h03);
    for (int i = 0; i < 6; i++) add_frame(8'hA0 + 8'(i), 4'h0);
    check_wave("push-at-pop frames 0xA0..0xA5", n + 2);

    // Reset during DATA with two bytes queued.
    bus_write(4'h2, 8'h04);
    bus_write(4'h0, 8'hA5);
    n = last_wr;
    bus_write(4'h0, 8'h11);
    bus_write(4'h0, 8'h22);
    bus_read(4'h1, d);
    chk("STATUS before reset", d, 8'h01);
    wait_until(n + 32);
    arst_n = 1'b0;
    #1;
    chk("txd high on reset", txd, 1);
    chk("readdata cleared on reset", rdata, 8'h00);
    chk("irq low on reset", irq, 0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    r = cyc;
    bus_read(4'h3, d);
    chk("LEVEL after reset", d, 8'h00);
    bus_read(4'h1, d);
    chk("STATUS after reset", d, 8'h04);
    bus_read(4'h2, d);
    chk("CTRL after reset", d, 8'h00);
    wait_until(r + 155);
    chk("no frame after reset release", find_fall(r, r + 150), -1);

    // Interrupt on idle and empty.
    bus_write(4'h2, 8'h08);
    chk("irq with IRQ_EN while idle", irq, 1);
    bus_write(4'h0, 8'h3C);
    n = last_wr;
    chk("irq drops cycle after push", irq, 0);
    s = n + 2;
    add_frame(8'h3C, 4'h8);
    check_wave("irq test frame 0x3C", s);
    ones = 0;
    for (int j = n + 1; j <= s + 99; j++) if (irqlog[j] !== 1'b0) ones++;
    chk("irq low during frame", ones, 0);
    chk("irq after STOP", irqlog[s+100], 1);
    bus_write(4'h2, 8'h00);
    chk("irq off with IRQ_EN cleared", irq, 0);

    // Randomized bursts against a queue-level model.
    for (int rnd = 0; rnd < 10; rnd++) begin
      c = 4'($urandom_range(0, 7));
      bus_write(4'h2, {4'h0, c});
      k = $urandom_range(1, 6);
      for (int j = 0; j < k; j++) begin
        rb[j] = 8'($urandom);
        bus_write(4'h0, rb[j]);
        if (j == 0) n = last_wr;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      sent = (k < 5) ? k : 5;
      lvl  = sent - 1;
      ovf  = (k > 5);
      bus_read(4'h3, d);
      chk($sformatf("random %0d LEVEL", rnd), d, 8'(lvl));
      bus_read(4'h1, d);
      chk($sformatf("random %0d STATUS", rnd), d,
          {4'h0, ovf, 1'(lvl == 0), 1'(lvl == 4), 1'b1});
      if (ovf) bus_write(4'h1, 8'h08);
      for (int j = 0; j < sent; j++) add_frame(rb[j], c);
      check_wave($sformatf("random %0d frames", rnd), n + 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
